softmax_host_ctrl: RTL and testbench

//  Initiator side of the softmax engine port. Collects one vector (1..2**INPUTMAX

---
 rtl/softmax_pkg.sv | 18 +
 rtl/softmax_host_ctrl_if.sv | 30 +++
 rtl/sm_vec_buffer.sv | 28 ++
 rtl/softmax_host_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_softmax_host_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/softmax_pkg.sv
// Shared sizing and FSM state encoding for the softmax host controller.
package softmax_pkg;

  localparam int unsigned DATALENGTH = 32;
  localparam int unsigned INPUTMAX   = 2;
  localparam int unsigned DEPTH      = 2 ** INPUTMAX;
  localparam int unsigned CntW       = INPUTMAX + 1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCollect = 3'd1,
    StStart   = 3'd2,
    StFeed    = 3'd3,
    StWait    = 3'd4,
    StDrain   = 3'd5
  } sm_state_e;

endpackage

// File: rtl/softmax_host_ctrl_if.sv
// Upstream stream, engine port and downstream stream of the softmax host controller.
interface softmax_host_ctrl_if;
  import softmax_pkg::*;

  logic [DATALENGTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic                  sm_start;
  logic [DATALENGTH-1:0] sm_datain;
  logic [INPUTMAX:0]     sm_n;
  logic [DATALENGTH-1:0] sm_dataout;
  logic                  sm_out_valid;
  logic [DATALENGTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;
  logic                  error;

  modport master (
    input  in_data, in_valid, in_last, sm_dataout, sm_out_valid, out_ready,
    output in_ready, sm_start, sm_datain, sm_n, out_data, out_valid, out_last, error
  );

  modport slave (
    output in_data, in_valid, in_last, sm_dataout, sm_out_valid, out_ready,
    input  in_ready, sm_start, sm_datain, sm_n, out_data, out_valid, out_last, error
  );

endinterface

// File: rtl/sm_vec_buffer.sv
// DEPTH x DATALENGTH register file: one write port, one asynchronous read port.
module sm_vec_buffer
  import softmax_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [INPUTMAX-1:0]   wr_idx_i,
  input  logic [DATALENGTH-1:0] wr_data_i,
  input  logic [INPUTMAX-1:0]   rd_idx_i,
  output logic [DATALENGTH-1:0] rd_data_o
);

  logic [DATALENGTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/softmax_host_ctrl.sv
// Softmax engine initiator: collect vector, start/feed engine, reorder results, drain.
// Optional WAIT watchdog with sticky error: define SM_HOST_TIMEOUT_EN.
module softmax_host_ctrl
  import softmax_pkg::*;
`ifdef SM_HOST_TIMEOUT_EN
#(
  parameter int unsigned TMO_CYCLES = 1024
)
`endif
(
  input logic                 clk_i,
  input logic                 rst_ni,
  softmax_host_ctrl_if.master host_io
);

  sm_state_e             state_q;
  logic [CntW-1:0]       cnt_q;
  logic [CntW-1:0]       sm_n_q;
  logic                  in_ready_q;
  logic                  sm_start_q;
  logic [DATALENGTH-1:0] sm_datain_q;
  logic                  out_valid_q;
  logic                  out_last_q;

  logic                  in_accept;
  logic                  res_strobe;
  logic                  buf_wr_en;
  logic [INPUTMAX-1:0]   buf_wr_idx;
  logic [DATALENGTH-1:0] buf_wr_data;
  logic [DATALENGTH-1:0] buf_rd_data;

`ifdef SM_HOST_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TMO_CYCLES + 1);
  logic [WdogW-1:0] wdog_q;
  logic             error_q;
`endif

  assign in_accept  = host_io.in_valid && in_ready_q;
  assign res_strobe = (state_q == StWait) && host_io.sm_out_valid;

  // Single write port: input beats in IDLE/COLLECT, reversed results in WAIT.
  always_comb begin
    buf_wr_en   = 1'b0;
    buf_wr_idx  = '0;
    buf_wr_data = '0;
    if (in_accept) begin
      buf_wr_en   = 1'b1;
      buf_wr_idx  = cnt_q[INPUTMAX-1:0];
      buf_wr_data = host_io.in_data;
    end else if (res_strobe) begin
      buf_wr_en   = 1'b1;
      buf_wr_idx  = INPUTMAX'(sm_n_q - cnt_q);
      buf_wr_data = host_io.sm_dataout;
    end
  end

  sm_vec_buffer u_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (buf_wr_en),
    .wr_idx_i  (buf_wr_idx),
    .wr_data_i (buf_wr_data),
    .rd_idx_i  (cnt_q[INPUTMAX-1:0]),
    .rd_data_o (buf_rd_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sm_n_q      <= '0;
      in_ready_q  <= 1'b0;
      sm_start_q  <= 1'b0;
      sm_datain_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef SM_HOST_TIMEOUT_EN
      wdog_q      <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      sm_start_q <= 1'b0;
      unique case (state_q)
        StIdle, StCollect: begin
          in_ready_q <= 1'b1;
          if (in_accept) begin
            if (host_io.in_last || (cnt_q == CntW'(DEPTH - 1))) begin
              state_q    <= StStart;
              in_ready_q <= 1'b0;
              sm_start_q <= 1'b1;
              sm_n_q     <= cnt_q;
              cnt_q      <= '0;
            end else begin
              state_q <= StCollect;
              cnt_q   <= cnt_q + CntW'(1);
            end
          end
        end
        StStart: begin
          state_q     <= StFeed;
          sm_datain_q <= buf_rd_data;
          cnt_q       <= CntW'(1);
        end
        // cnt_q runs one ahead of the word currently on sm_datain.
        StFeed: begin
          if (cnt_q == sm_n_q + CntW'(1)) begin
            state_q     <= StWait;
            sm_datain_q <= '0;
            cnt_q       <= '0;
`ifdef SM_HOST_TIMEOUT_EN
            wdog_q      <= '0;
`endif
          end else begin
            sm_datain_q <= buf_rd_data;
            cnt_q       <= cnt_q + CntW'(1);
          end
        end
        StWait: begin
          if (host_io.sm_out_valid) begin
`ifdef SM_HOST_TIMEOUT_EN
            wdog_q <= '0;
`endif
            if (cnt_q == sm_n_q) begin
              state_q     <= StDrain;
              cnt_q       <= '0;
              out_valid_q <= 1'b1;
              out_last_q  <= (sm_n_q == '0);
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
`ifdef SM_HOST_TIMEOUT_EN
          else if (wdog_q == WdogW'(TMO_CYCLES - 1)) begin
            state_q    <= StIdle;
            error_q    <= 1'b1;
            wdog_q     <= '0;
            cnt_q      <= '0;
            sm_n_q     <= '0;
            in_ready_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WdogW'(1);
          end
`endif
        end
        StDrain: begin
          if (host_io.out_ready) begin
            if (out_last_q) begin
              state_q     <= StIdle;
              cnt_q       <= '0;
              sm_n_q      <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
            end else begin
              cnt_q      <= cnt_q + CntW'(1);
              out_last_q <= ((cnt_q + CntW'(1)) == sm_n_q);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign host_io.in_ready  = in_ready_q;
  assign host_io.sm_start  = sm_start_q;
  assign host_io.sm_datain = sm_datain_q;
  assign host_io.sm_n      = sm_n_q;
  assign host_io.out_valid = out_valid_q;
  assign host_io.out_last  = out_last_q;
  // Read port is indexed by cnt_q, which is frozen while the downstream stalls.
  assign host_io.out_data  = out_valid_q ? buf_rd_data : '0;

`ifdef SM_HOST_TIMEOUT_EN
  assign host_io.error = error_q;
`else
  assign host_io.error = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_host_ctrl.sv
// Directed bench for softmax_host_ctrl; drives/samples on the falling clock edge.
module tb_softmax_host_ctrl;

  logic clk;
  logic rst_n;

  softmax_host_ctrl_if bus ();

`ifdef SM_HOST_TIMEOUT_EN
  softmax_host_ctrl #(.TMO_CYCLES(16)) u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .host_io (bus)
  );
`else
  softmax_host_ctrl u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .host_io (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] vec [5];
  logic [31:0] res [4];
  logic        exp_error = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " sm_start"}, 32'(bus.sm_start), 32'd0);
    check_eq({tag, " sm_datain"}, bus.sm_datain, 32'd0);
    check_eq({tag, " sm_n"}, 32'(bus.sm_n), 32'd0);
    check_eq({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, " out_data"}, bus.out_data, 32'd0);
    check_eq({tag, " out_last"}, 32'(bus.out_last), 32'd0);
    check_eq({tag, " error"}, 32'(bus.error), 32'(exp_error));
  endtask

  // Presents n words; returns at the falling edge of the START cycle.
  task automatic send_vec(input string tag, input int n, input bit with_last);
    int guard;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vec[i];
      bus.in_last  = with_last && (i == n - 1);
      guard = 0;
      while (!bus.in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) check_eq({tag, " in_ready_wait"}, 32'(guard), 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  // From the START falling edge to the first WAIT falling edge.
  task automatic feed_phase(input string tag, input int n);
    check_eq({tag, " sm_start"}, 32'(bus.sm_start), 32'd1);
    check_eq({tag, " sm_n"}, 32'(bus.sm_n), 32'(n - 1));
    check_eq({tag, " in_ready_start"}, 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_eq({tag, $sformatf(" feed%0d", k)}, bus.sm_datain, vec[k]);
      if (k == 0) check_eq({tag, " start_pulse_end"}, 32'(bus.sm_start), 32'd0);
    end
    @(negedge clk);
    check_eq({tag, " wait_datain"}, bus.sm_datain, 32'd0);
  endtask

  // Engine returns results in descending index order, then the host drains ascending.
  task automatic engine_drain(input string tag, input int n, input int stall);
    for (int j = 0; j < n; j++) begin
      bus.sm_out_valid = 1'b1;
      bus.sm_dataout   = res[n - 1 - j];
      @(negedge clk);
    end
    bus.sm_out_valid = 1'b0;
    bus.sm_dataout   = '0;
    check_eq({tag, " drain_valid"}, 32'(bus.out_valid), 32'd1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq({tag, $sformatf(" stall%0d", s)}, {bus.out_data[30:0], bus.out_valid}, {res[0][30:0], 1'b1});
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      check_eq({tag, $sformatf(" out%0d", k)}, bus.out_data, res[k]);
      check_eq({tag, $sformatf(" last%0d", k)}, 32'(bus.out_last), 32'(k == n - 1));
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    check_eq({tag, " post_in_ready"}, 32'(bus.in_ready), 32'd1);
    check_idle_outputs({tag, " post"});
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.in_data      = '0;
    bus.in_valid     = 1'b0;
    bus.in_last      = 1'b0;
    bus.sm_dataout   = '0;
    bus.sm_out_valid = 1'b0;
    bus.out_ready    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst in_ready", 32'(bus.in_ready), 32'd0);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    #1;
    check_eq("rel in_ready first", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check_eq("rel in_ready", 32'(bus.in_ready), 32'd1);

    // Four words 1.0..4.0 with InLast on the fourth.
    vec[0] = 32'h3F80_0000; vec[1] = 32'h4000_0000;
    vec[2] = 32'h4040_0000; vec[3] = 32'h4080_0000;
    res[0] = 32'h3D03_5FA0; res[1] = 32'h3DB2_7A1C;
    res[2] = 32'h3E72_9064; res[3] = 32'h3F24_D7E8;
    send_vec("v4", 4, 1'b1);
    feed_phase("v4", 4);
    engine_drain("v4", 4, 0);

    // Single word with InLast on the first beat.
    vec[0] = 32'h4120_0000;
    res[0] = 32'h3F80_0000;
    send_vec("v1", 1, 1'b1);
    feed_phase("v1", 1);
    engine_drain("v1", 1, 0);

    // Five words, no InLast: only four taken; fifth stays pending. Drain stalled 10 cycles.
    vec[0] = 32'h0000_0011; vec[1] = 32'h0000_0022; vec[2] = 32'h0000_0033;
    vec[3] = 32'h0000_0044; vec[4] = 32'h0000_0055;
    res[0] = 32'hA0A0_0000; res[1] = 32'hA1A1_0001;
    res[2] = 32'hA2A2_0002; res[3] = 32'hA3A3_0003;
    send_vec("v5", 4, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = vec[4];
    feed_phase("v5", 4);
    check_eq("v5 fifth_not_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    engine_drain("v5", 4, 10);

    // Reset in WAIT after one result strobe aborts everything.
    vec[0] = 32'h0000_0101; vec[1] = 32'h0000_0202; vec[2] = 32'h0000_0303;
    send_vec("vr", 3, 1'b1);
    feed_phase("vr", 3);
    bus.sm_out_valid = 1'b1;
    bus.sm_dataout   = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.sm_out_valid = 1'b0;
    bus.sm_dataout   = '0;
    rst_n = 1'b0;
    #1;
    check_eq("abort in_ready", 32'(bus.in_ready), 32'd0);
    exp_error = 1'b0;
    check_idle_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort rel in_ready", 32'(bus.in_ready), 32'd1);

    vec[0] = 32'h0000_0A0A; vec[1] = 32'h0000_0B0B;
    res[0] = 32'hC000_0010; res[1] = 32'hC000_0011;
    send_vec("v2", 2, 1'b1);
    feed_phase("v2", 2);
    engine_drain("v2", 2, 0);

`ifdef SM_HOST_TIMEOUT_EN
    begin
      int cyc;
      bit seen_ov;
      vec[0] = 32'h0000_7777; vec[1] = 32'h0000_8888;
      send_vec("tmo", 2, 1'b1);
      feed_phase("tmo", 2);
      cyc = 0;
      seen_ov = 1'b0;
      while (!bus.error && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (bus.out_valid) seen_ov = 1'b1;
      end
      check_eq("tmo cycles", 32'(cyc), 32'd16);
      check_eq("tmo error", 32'(bus.error), 32'd1);
      check_eq("tmo in_ready", 32'(bus.in_ready), 32'd1);
      check_eq("tmo no_out_valid", 32'(seen_ov), 32'd0);
      exp_error = 1'b1;
      vec[0] = 32'h0000_9999;
      res[0] = 32'hE000_0001;
      send_vec("tmo_next", 1, 1'b1);
      feed_phase("tmo_next", 1);
      engine_drain("tmo_next", 1, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "global timeout");
  end

endmodule
